word_serial_tx: RTL and testbench

Framed serial transmitter for BITS-wide words, e.g. the registered output of the bitwise-NAND datapath register.
- Accepts one word per valid/ready handshake.
- Sends it on a single line, LSB first: start bit, BITS data bits, optional even-parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits at the datapath edge and drives a one-wire link to a matching receiver.

---
 rtl/word_serial_tx.sv | 78 +++++++
 tb/tb_word_serial_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/word_serial_tx.sv
// word_serial_tx: framed LSB-first serial transmitter (start, data, optional even parity, stop)
module word_serial_tx #(
  parameter int BITS         = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            tx_out,
  output logic            busy,
  output logic            done
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = BITS > 1 ? $clog2(BITS) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic [BITS-1:0] sh, sh_n;
  logic par, par_n, tx_n, last;
  assign in_ready = state == IDLE;
  assign last = timer == LAST;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    timer_n = last ? '0 : timer + TW'(1);
    case (state)
      IDLE: begin
        timer_n = '0;
        if (in_valid) begin
          state_n = START;
          sh_n    = in_data;
          par_n   = ^in_data;
        end
      end
      START: if (last) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (last) begin
        sh_n  = sh >> 1;
        idx_n = idx + IW'(1);
        if (idx == IW'(BITS - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (last) state_n = STOP;
      default: if (last) state_n = IDLE;
    endcase
    // outputs are registered, so they are decoded from the state being entered
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      sh     <= sh_n;
      par    <= par_n;
      tx_out <= tx_n;
      busy   <= state_n != IDLE;
      done   <= state_n == STOP && timer_n == LAST;
    end
  end
endmodule

// File: tb/tb_word_serial_tx.sv
// tb_word_serial_tx: directed frame checks for word_serial_tx (4-bit parity build and 1-clock no-parity build)
module tb_word_serial_tx;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_valid2 = 0;
  logic [3:0] in_data = 0, in_data2 = 0;
  logic in_ready, tx_out, busy, done;
  logic in_ready2, tx_out2, busy2, done2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  word_serial_tx #(.BITS(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done));

  word_serial_tx #(.BITS(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .tx_out(tx_out2), .busy(busy2), .done(done2));

  typedef struct {
    logic [3:0] word;
    logic [6:0] pattern;
    logic       hold;
    logic [3:0] alt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    in_valid = 1;
    in_data  = v.word;
    chk("ready_before_accept", in_ready, 1);
    tick();
    if (v.hold) in_data = v.alt;
    else in_valid = 0;
    for (int k = 0; k < 28; k++) begin
      chk($sformatf("tx_%0h_k%0d", v.word, k), tx_out, v.pattern[k/4]);
      chk($sformatf("busy_%0h_k%0d", v.word, k), busy, 1);
      chk($sformatf("done_%0h_k%0d", v.word, k), done, k == 27);
      chk($sformatf("ready_%0h_k%0d", v.word, k), in_ready, 0);
      tick();
    end
    chk("idle_tx", tx_out, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    // pattern bit0 = start, bits1..4 = data LSB first, bit5 = parity, bit6 = stop
    vecs[0] = '{4'b1011, 7'b1110110, 1'b0, 4'h0};
    vecs[1] = '{4'h5,    7'b1001010, 1'b1, 4'hA};
    vecs[2] = '{4'hA,    7'b1010100, 1'b0, 4'h0};
    vecs[3] = '{4'hF,    7'b1011110, 1'b1, 4'h0};
    vecs[4] = '{4'h0,    7'b1000000, 1'b0, 4'h0};
    vecs[5] = '{4'h7,    7'b1101110, 1'b0, 4'h0};

    reset = 0;
    in_valid = 1;
    in_data = 4'h9;
    repeat (3) tick();
    chk("reset_beats_accept_busy", busy, 0);
    chk("reset_beats_accept_tx", tx_out, 1);
    in_valid = 0;
    reset = 1;
    for (int i = 0; i < 20; i++) begin
      chk("rst_idle_tx", tx_out, 1);
      chk("rst_idle_busy", busy, 0);
      chk("rst_idle_done", done, 0);
      chk("rst_idle_ready", in_ready, 1);
      tick();
    end

    for (int i = 0; i < 6; i++) send_frame(vecs[i]);
    in_valid = 0;
    tick();

    in_valid = 1;
    in_data = 4'h3;
    tick();
    in_valid = 0;
    repeat (9) begin
      chk("midframe_busy", busy, 1);
      chk("midframe_done", done, 0);
      tick();
    end
    reset = 0;
    tick();
    chk("midrst_tx", tx_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_done", done, 0);
    reset = 1;
    repeat (30) begin
      chk("after_rst_no_done", done, 0);
      chk("after_rst_line_idle", tx_out, 1);
      tick();
    end
    send_frame(vecs[4]);
    in_valid = 0;
    tick();

    in_valid2 = 1;
    in_data2 = 4'b0110;
    chk("fast_ready", in_ready2, 1);
    tick();
    in_valid2 = 0;
    for (int k = 0; k < 6; k++) begin
      logic [5:0] fast_pat;
      fast_pat = 6'b101100;
      chk($sformatf("fast_tx_k%0d", k), tx_out2, fast_pat[k]);
      chk($sformatf("fast_busy_k%0d", k), busy2, 1);
      chk($sformatf("fast_done_k%0d", k), done2, k == 5);
      tick();
    end
    chk("fast_idle_busy", busy2, 0);
    chk("fast_idle_ready", in_ready2, 1);
    chk("fast_idle_tx", tx_out2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
